// File: rtl/button_event_decoder.sv
// Button event decoder.
// Takes the debounced button level and turns each press sequence into
// exactly one single-cycle event: short press, double press or long press.
// Also provides a "held" level that stays high from the long-press event
// until the button is released.
// The input is already synchronous to clk, so it is only registered once
// (p_q) for polarity normalisation. Every FSM decision looks at that register.
module button_event_decoder #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int LONG_MS     = 1000,
  parameter int DOUBLE_MS   = 300,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic pressed,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic held
);

  localparam int LONG_TICKS   = CLK_FREQ_HZ / 1000 * LONG_MS;
  localparam int DOUBLE_TICKS = CLK_FREQ_HZ / 1000 * DOUBLE_MS;
  localparam int MAX_TICKS    = (LONG_TICKS > DOUBLE_TICKS) ? LONG_TICKS : DOUBLE_TICKS;
  localparam int CNT_W        = $clog2(MAX_TICKS + 1);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  // Both windows need at least two ticks so that the "last tick" compare
  // lands on a cycle after the state was entered.
  if (LONG_TICKS < 2) begin : g_bad_long
    $error("button_event_decoder: LONG_TICKS must be at least 2");
  end
  if (DOUBLE_TICKS < 2) begin : g_bad_double
    $error("button_event_decoder: DOUBLE_TICKS must be at least 2");
  end

  // FSM encoding.
  localparam logic [2:0] ST_IDLE   = 3'd0;  // waiting for a first press
  localparam logic [2:0] ST_PRESS1 = 3'd1;  // first press down, timing for long
  localparam logic [2:0] ST_WAIT2  = 3'd2;  // released, timing the double window
  localparam logic [2:0] ST_PRESS2 = 3'd3;  // second press down, waits for release
  localparam logic [2:0] ST_LHELD  = 3'd4;  // long press reported, waits for release

  logic             p_q;
  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             ev_short;
  logic             ev_double;
  logic             ev_long;

  assign pressed = p_q;

  // Register the input with its polarity normalised to 1 = pressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= 1'b0;
    end else begin
      p_q <= in ^ ACTIVE_LOW;
    end
  end

  // Next-state and event decode; release wins over long expiry and a
  // re-press wins over the double-window expiry.
  always_comb begin
    state_nxt = state;
    ev_short  = 1'b0;
    ev_double = 1'b0;
    ev_long   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (p_q) state_nxt = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (!p_q) begin
          state_nxt = ST_WAIT2;
        end else if (cnt == LONG_LAST) begin
          state_nxt = ST_LHELD;
          ev_long   = 1'b1;
        end
      end
      ST_WAIT2: begin
        if (p_q) begin
          state_nxt = ST_PRESS2;
        end else if (cnt == DOUBLE_LAST) begin
          state_nxt = ST_IDLE;
          ev_short  = 1'b1;
        end
      end
      ST_PRESS2: begin
        if (!p_q) begin
          state_nxt = ST_IDLE;
          ev_double = 1'b1;
        end
      end
      ST_LHELD: begin
        if (!p_q) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Dwell counter: restarts on every state change, otherwise saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Registered event pulses and the held level, set on the transition edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      short_press  <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      held         <= 1'b0;
    end else begin
      short_press  <= ev_short;
      double_press <= ev_double;
      long_press   <= ev_long;
      held         <= (state_nxt == ST_LHELD);
    end
  end

endmodule
